// File: rtl/pg_in_if.sv
// Operand/result bundle for the prefix-adder input stage.
// Latency: none, wiring only.
// Backpressure: none; a producer may assert in_valid every cycle.
interface pg_in_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c_in;
   logic             out_valid;
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;

   // Operand source: drives the operands and observes the registered G/P result.
   modport master (
      output in_valid, x, y, c_in,
      input  out_valid, gen, prop
   );

   // G/P stage: consumes operands and drives the registered result.
   modport slave (
      input  in_valid, x, y, c_in,
      output out_valid, gen, prop
   );
endinterface

// File: rtl/pg_in.sv
// Input stage of a parallel-prefix adder: per-bit generate/propagate, carry-in folded into bit 0.
// Latency: one cycle from an in_valid edge to gen/prop/out_valid.
// Backpressure: none; accepts an operand pair every cycle, holds results while in_valid is low.
module pg_in #(
   parameter int WIDTH = 16   // legal range 1..64
) (
   input  logic   clk,
   input  logic   rst_n,
   pg_in_if.slave bus
);

   logic [WIDTH-1:0] gen_nxt;
   logic [WIDTH-1:0] prop_nxt;
   logic [WIDTH-1:0] gen_q;
   logic [WIDTH-1:0] prop_q;
   logic             vld_q;

   // Bitwise G/P terms; bit 0 absorbs c_in so it becomes majority(x0, y0, c_in).
   always_comb begin
      prop_nxt   = bus.x ^ bus.y;
      gen_nxt    = bus.x & bus.y;
      gen_nxt[0] = (bus.x[0] & bus.y[0]) | (prop_nxt[0] & bus.c_in);
   end

   // Result registers: capture only on valid edges so idle-cycle operands
   // (possibly X) never reach the outputs. Reset clears everything at once,
   // which also discards a result that was about to be presented. Release is
   // expected to arrive clock-aligned from the reset synchronizer upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         gen_q  <= '0;
         prop_q <= '0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            gen_q  <= gen_nxt;
            prop_q <= prop_nxt;
         end
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.gen       = gen_q;
   assign bus.prop      = prop_q;

endmodule

// File: tb/tb_pg_in.sv
// Self-checking bench for pg_in: directed spec vectors plus a long random run
// compared against an arithmetic per-bit reference model.
module tb_pg_in;
   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   logic [W-1:0] exp_gen;
   logic [W-1:0] exp_prop;

   pg_in_if #(.WIDTH(W)) bus ();

   pg_in #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference generate: a bit generates when its column sum (plus c_in at bit 0) reaches 2.
   function automatic logic [W-1:0] ref_gen(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         int s;
         s = int'(a[i]) + int'(b[i]) + ((i == 0) ? int'(c) : 0);
         r[i] = (s >= 2);
      end
      return r;
   endfunction

   // Reference propagate: column sum of the two operand bits is exactly 1.
   function automatic logic [W-1:0] ref_prop(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = ((int'(a[i]) + int'(b[i])) == 1);
      return r;
   endfunction

   // Drive one cycle's inputs on the falling edge, then sample just after the rising edge.
   task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      bus.in_valid = v;
      bus.x        = a;
      bus.y        = b;
      bus.c_in     = c;
      if (v) begin
         exp_gen  = ref_gen(a, b, c);
         exp_prop = ref_prop(a, b);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   initial begin
      logic [7:0] tbl_gen;
      logic [7:0] tbl_prop;
      logic [2:0] tbl_xyc [8];
      logic [W-1:0] ha, hb;

      n_cmp = 0;
      n_err = 0;
      exp_gen  = '0;
      exp_prop = '0;
      bus.in_valid = 1'b0;
      bus.x        = '0;
      bus.y        = '0;
      bus.c_in     = 1'b0;

      // Reset state, asserted before any clock edge.
      rst_n = 1'b0;
      #3;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_gen",       64'(bus.gen),       64'd0);
      check("rst_prop",      64'(bus.prop),      64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive bit 0: {x0,y0,c} in the listed order with upper bits zero.
      tbl_xyc  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
      tbl_gen  = 8'b1110_1000;   // entry k at bit k: 0,0,0,1,0,1,1,1
      tbl_prop = 8'b0110_0110;   // entry k at bit k: 0,1,1,0,0,1,1,0
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, W'(tbl_xyc[k][2]), W'(tbl_xyc[k][1]), tbl_xyc[k][0]);
         check($sformatf("bit0_gen_%0d", k),  64'(bus.gen),  64'(tbl_gen[k]));
         check($sformatf("bit0_prop_%0d", k), 64'(bus.prop), 64'(tbl_prop[k]));
         check($sformatf("bit0_vld_%0d", k),  64'(bus.out_valid), 64'd1);
      end

      // Directed vectors from the spec, expected values as literals.
      cycle(1'b1, 16'h00FF, 16'h0F0F, 1'b0);
      check("vec_gen",  64'(bus.gen),       64'h000F);
      check("vec_prop", 64'(bus.prop),      64'h0FF0);
      check("vec_vld",  64'(bus.out_valid), 64'd1);
      cycle(1'b1, 16'h0001, 16'h0000, 1'b1);
      check("cin1_gen",  64'(bus.gen),  64'h0001);
      check("cin1_prop", 64'(bus.prop), 64'h0001);
      cycle(1'b1, 16'h0001, 16'h0000, 1'b0);
      check("cin0_gen",  64'(bus.gen),  64'h0000);
      check("cin0_prop", 64'(bus.prop), 64'h0001);

      // Hold: one valid pair, then three idle cycles with junk (and X) on the operands.
      ha = rnd() | 16'h8001;
      hb = rnd() | 16'h0101;
      cycle(1'b1, ha, hb, 1'b1);
      check("hold_load_gen",  64'(bus.gen),  64'(exp_gen));
      check("hold_load_prop", 64'(bus.prop), 64'(exp_prop));
      for (int k = 0; k < 3; k++) begin
         if (k == 1) cycle(1'b0, 'x, 'x, 1'bx);
         else        cycle(1'b0, rnd(), rnd(), $urandom_range(0, 1) == 1);
         check($sformatf("hold_gen_%0d", k),  64'(bus.gen),       64'(exp_gen));
         check($sformatf("hold_prop_%0d", k), 64'(bus.prop),      64'(exp_prop));
         check($sformatf("hold_vld_%0d", k),  64'(bus.out_valid), 64'd0);
      end

      // Mid-stream reset: assert between edges while a result is being presented.
      cycle(1'b1, 16'hFFFF, 16'hF0F0, 1'b1);
      check("prerst_vld", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_vld",  64'(bus.out_valid), 64'd0);
      check("arst_gen",  64'(bus.gen),       64'd0);
      check("arst_prop", 64'(bus.prop),      64'd0);
      // Valid operands offered while in reset must not be captured.
      cycle(1'b1, 16'hAAAA, 16'hFFFF, 1'b1);
      check("inrst_vld", 64'(bus.out_valid), 64'd0);
      check("inrst_gen", 64'(bus.gen),       64'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      exp_gen  = '0;
      exp_prop = '0;
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, rnd(), rnd(), 1'b1);
         check($sformatf("postrst_vld_%0d", k),  64'(bus.out_valid), 64'd0);
         check($sformatf("postrst_gen_%0d", k),  64'(bus.gen),       64'd0);
         check($sformatf("postrst_prop_%0d", k), 64'(bus.prop),      64'd0);
      end

      // First capture right after release.
      cycle(1'b1, 16'h1234, 16'h4321, 1'b1);
      check("first_gen", 64'(bus.gen), 64'(exp_gen));
      check("first_vld", 64'(bus.out_valid), 64'd1);

      // Back-to-back random vectors against the reference model.
      for (int k = 0; k < 10000; k++) begin
         cycle(1'b1, rnd(), rnd(), $urandom_range(0, 1) == 1);
         check("rand_gen",  64'(bus.gen),       64'(exp_gen));
         check("rand_prop", 64'(bus.prop),      64'(exp_prop));
         check("rand_vld",  64'(bus.out_valid), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
